uart_bridge_responder: RTL

Byte-level command responder sitting behind the UART transceiver's parallel side: consumes received bytes (`rx_data`/`rx_done`), decodes read/write command frames, performs 32-bit single-word bus transactions and returns read data through the transmitter's `tx_data`/`tx_wr`/`tx_done` handshake. It is the target end of a host-driven debug link and gives an external PC access to the SoC's 32-bit register bus over the serial line.

---
 rtl/uart_bridge_pkg.sv | 33 +++
 rtl/uart_bridge_responder_if.sv | 37 +++
 rtl/uart_bridge_timeout.sv | 35 +++
 rtl/uart_bridge_responder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// ----------------------------------------------------------------------------
// uart_bridge_pkg : shared constants, command codes and FSM state encoding
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_bridge_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WDATA = 3'd3,
    ST_WBUS  = 3'd4,
    ST_RBUS  = 3'd5,
    ST_RSEND = 3'd6,
    ST_RWAIT = 3'd7
  } state_t;

  // A LEN byte of zero encodes the maximum burst of 256 words.
  function automatic logic [8:0] len_to_words(input logic [7:0] len);
    return (len == 8'h00) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_bridge_responder_if.sv
// ----------------------------------------------------------------------------
// uart_bridge_responder_if : UART byte handshake plus 32-bit register bus
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface uart_bridge_responder_if;
  import uart_bridge_pkg::*;

  logic [7:0]        rx_data;
  logic              rx_done;
  logic [7:0]        tx_data;
  logic              tx_wr;
  logic              tx_done;
  logic [ADDR_W-1:0] bus_adr;
  logic [DATA_W-1:0] bus_dat_w;
  logic [DATA_W-1:0] bus_dat_r;
  logic              bus_we;
  logic              bus_stb;
  logic              bus_ack;
  logic              busy;

  // slave: the responder itself
  modport slave (
    input  rx_data, rx_done, tx_done, bus_dat_r, bus_ack,
    output tx_data, tx_wr, bus_adr, bus_dat_w, bus_we, bus_stb, busy
  );

  // master: the UART transceiver and bus fabric around the responder
  modport master (
    output rx_data, rx_done, tx_done, bus_dat_r, bus_ack,
    input  tx_data, tx_wr, bus_adr, bus_dat_w, bus_we, bus_stb, busy
  );

endinterface

`default_nettype wire

// File: rtl/uart_bridge_timeout.sv
// ----------------------------------------------------------------------------
// uart_bridge_timeout : inter-byte idle-gap counter with single-cycle expire
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_bridge_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_clear,
  input  wire logic i_enable,
  output logic      o_expire
);

  localparam int unsigned     CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear || !i_enable) begin
      r_cnt <= '0;
    end else if (r_cnt != c_LAST) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A byte arriving on the final count still wins over the expiry.
  assign o_expire = i_enable && !i_clear && (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_bridge_responder.sv
// ----------------------------------------------------------------------------
// uart_bridge_responder : UART command frames -> 32-bit single-word bus cycles
// Optional idle-gap timeout enabled by UART_BRIDGE_TIMEOUT_EN.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_bridge_responder
  import uart_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  wire logic               sys_clk,
  input  wire logic               sys_rst,
  uart_bridge_responder_if.slave  bus
);

  state_t            r_state;
  logic [1:0]        r_byte_cnt;
  logic [8:0]        r_words;
  logic              r_is_write;
  logic [23:0]       r_rdata;
  logic [7:0]        r_tx_data;
  logic              r_tx_wr;
  logic [ADDR_W-1:0] r_bus_adr;
  logic [DATA_W-1:0] r_bus_dat_w;
  logic              r_bus_we;
  logic              r_bus_stb;
  logic              r_busy;
  logic              w_expire;

`ifdef UART_BRIDGE_TIMEOUT_EN
  logic w_to_enable;
  assign w_to_enable = (r_state == ST_LEN) || (r_state == ST_ADDR) || (r_state == ST_WDATA);

  uart_bridge_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .i_clear  (bus.rx_done),
    .i_enable (w_to_enable),
    .o_expire (w_expire)
  );
`else
  // Without the idle timer a frame waits forever; the parameter stays referenced.
  assign w_expire = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= ST_IDLE;
      r_byte_cnt  <= '0;
      r_words     <= '0;
      r_is_write  <= 1'b0;
      r_rdata     <= '0;
      r_tx_data   <= '0;
      r_tx_wr     <= 1'b0;
      r_bus_adr   <= '0;
      r_bus_dat_w <= '0;
      r_bus_we    <= 1'b0;
      r_bus_stb   <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_expire) begin
      r_state    <= ST_IDLE;
      r_byte_cnt <= '0;
      r_words    <= '0;
      r_tx_wr    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_tx_wr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.rx_done && (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ)) begin
            r_is_write <= (bus.rx_data == CMD_WRITE);
            r_state    <= ST_LEN;
            r_busy     <= 1'b1;
          end
        end

        ST_LEN: begin
          if (bus.rx_done) begin
            r_words    <= len_to_words(bus.rx_data);
            r_byte_cnt <= '0;
            r_state    <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          if (bus.rx_done) begin
            r_bus_adr  <= {r_bus_adr[23:0], bus.rx_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              if (r_is_write) begin
                r_state <= ST_WDATA;
              end else begin
                r_state   <= ST_RBUS;
                r_bus_stb <= 1'b1;
                r_bus_we  <= 1'b0;
              end
            end
          end
        end

        ST_WDATA: begin
          if (bus.rx_done) begin
            r_bus_dat_w <= {r_bus_dat_w[23:0], bus.rx_data};
            r_byte_cnt  <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state   <= ST_WBUS;
              r_bus_stb <= 1'b1;
              r_bus_we  <= 1'b1;
            end
          end
        end

        ST_WBUS: begin
          if (bus.bus_ack) begin
            r_bus_stb <= 1'b0;
            r_bus_we  <= 1'b0;
            r_bus_adr <= r_bus_adr + 32'd1;
            r_words   <= r_words - 9'd1;
            if (r_words == 9'd1) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_WDATA;
            end
          end
        end

        ST_RBUS: begin
          if (bus.bus_ack) begin
            r_bus_stb  <= 1'b0;
            r_bus_adr  <= r_bus_adr + 32'd1;
            r_tx_data  <= bus.bus_dat_r[31:24];
            r_rdata    <= bus.bus_dat_r[23:0];
            r_tx_wr    <= 1'b1;
            r_byte_cnt <= '0;
            r_state    <= ST_RSEND;
          end
        end

        ST_RSEND: begin
          r_state <= ST_RWAIT;
        end

        ST_RWAIT: begin
          if (bus.tx_done) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_words <= r_words - 9'd1;
              if (r_words == 9'd1) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state   <= ST_RBUS;
                r_bus_stb <= 1'b1;
              end
            end else begin
              r_tx_data <= r_rdata[23:16];
              r_rdata   <= {r_rdata[15:0], 8'h00};
              r_tx_wr   <= 1'b1;
              r_state   <= ST_RSEND;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_data   = r_tx_data;
  assign bus.tx_wr     = r_tx_wr;
  assign bus.bus_adr   = r_bus_adr;
  assign bus.bus_dat_w = r_bus_dat_w;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_stb   = r_bus_stb;
  assign bus.busy      = r_busy;

endmodule

`default_nettype wire
